// File: rtl/wbc_pkg.sv
// Shared definitions for the WISHBONE control interconnect arbiter: master indices,
// FSM encoding and default watchdog parameters.
package wbc_pkg;

  localparam int WBC_NUM_MASTERS = 3;
  localparam int WBC_M_BMC       = 0;
  localparam int WBC_M_SPIC      = 1;
  localparam int WBC_M_PCIEC     = 2;

  localparam int WBC_TIMEOUT_DEF = 1024;
  localparam int WBC_CNT_W_DEF   = 16;

  localparam logic [1:0] WBC_ST_IDLE  = 2'd0;
  localparam logic [1:0] WBC_ST_OWN   = 2'd1;
  localparam logic [1:0] WBC_ST_FLUSH = 2'd2;

  // Index width for an N-entry pointer; a single master still needs one bit.
  function automatic int wbc_ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wbc_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester above the last owner, wrapping.
// Zero latency; returns an all-zero grant when nothing requests.
module rr_pick #(
  parameter int N     = 3,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] last_i,
  output logic [N-1:0]     gnt_o
);

  always_comb begin
    logic [PTR_W-1:0] idx;
    logic             found;
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    // Offset 1..N so the last owner is considered last.
    for (int i = 1; i <= N; i++) begin
      idx = PTR_W'((int'(last_i) + i) % N);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wbc_bus_arbiter.sv
// Round-robin WISHBONE arbiter holding each grant for a whole cycle, with a strobe
// watchdog that pulses an error when the slave never terminates. All outputs registered.
module wbc_bus_arbiter
  import wbc_pkg::*;
#(
  parameter int NUM_MASTERS = WBC_NUM_MASTERS,
  parameter int TIMEOUT     = WBC_TIMEOUT_DEF,
  parameter int CNT_W       = WBC_CNT_W_DEF
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_MASTERS-1:0] cyc_i,
  input  logic                   stb_i,
  input  logic                   ack_i,
  input  logic                   err_i,
  input  logic                   rty_i,
  output logic [NUM_MASTERS-1:0] gnt_o,
  output logic                   wdog_err_o,
  output logic                   busy_o,
  output logic [CNT_W-1:0]       wdog_cnt_o,
  output logic [NUM_MASTERS-1:0] wdog_last_o,
  input  logic                   wdog_clr_i
);

  localparam int PTR_W = wbc_ptr_w(NUM_MASTERS);
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  logic [1:0]             state_q, state_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [WD_W-1:0]        wd_q, wd_d;
  logic                   err_q, err_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_MASTERS-1:0] last_q, last_d;

  logic [NUM_MASTERS-1:0] pick;
  logic                   owner_cyc;
  logic                   term;
  logic                   fire;

  assign owner_cyc = |(cyc_i & gnt_q);
  assign term      = ack_i | err_i | rty_i;

  rr_pick #(
    .N     (NUM_MASTERS),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req_i  (cyc_i),
    .last_i (ptr_q),
    .gnt_o  (pick)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    wd_d    = '0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    last_d  = last_q;
    fire    = 1'b0;

    case (state_q)
      WBC_ST_IDLE: begin
        if (|cyc_i) begin
          gnt_d   = pick;
          state_d = WBC_ST_OWN;
          for (int i = 0; i < NUM_MASTERS; i++) begin
            if (pick[i]) ptr_d = PTR_W'(i);
          end
        end
      end
      WBC_ST_OWN: begin
        // Owner release beats the watchdog; a termination also beats it by clearing wd.
        if (!owner_cyc) begin
          gnt_d   = '0;
          state_d = WBC_ST_IDLE;
        end else if (stb_i && !term) begin
          if (wd_q == WD_W'(TIMEOUT - 1)) begin
            fire    = 1'b1;
            state_d = WBC_ST_FLUSH;
          end else begin
            wd_d = wd_q + 1'b1;
          end
        end
      end
      WBC_ST_FLUSH: begin
        if (!owner_cyc) begin
          gnt_d   = '0;
          state_d = WBC_ST_IDLE;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = WBC_ST_IDLE;
      end
    endcase

    if (fire) begin
      err_d  = 1'b1;
      last_d = gnt_q;
      if (!(&cnt_q)) cnt_d = cnt_q + 1'b1;
    end

    if (wdog_clr_i) begin
      cnt_d  = '0;
      last_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= WBC_ST_IDLE;
      gnt_q   <= '0;
      ptr_q   <= PTR_W'(NUM_MASTERS - 1);
      wd_q    <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign busy_o      = |gnt_q;
  assign wdog_err_o  = err_q;
  assign wdog_cnt_o  = cnt_q;
  assign wdog_last_o = last_q;

endmodule

// File: tb/tb_wbc_bus_arbiter.sv
// Bench for wbc_bus_arbiter (TIMEOUT=8, CNT_W=2): grant and watchdog events are checked
// against expectation queues, cycle timing by directed checks.
module tb_wbc_bus_arbiter;
  import wbc_pkg::*;

  localparam logic [2:0] G_BMC   = 3'(1 << WBC_M_BMC);
  localparam logic [2:0] G_SPIC  = 3'(1 << WBC_M_SPIC);
  localparam logic [2:0] G_PCIEC = 3'(1 << WBC_M_PCIEC);

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] cyc;
  logic       stb, ack, err, rty, clr;
  logic [2:0] gnt;
  logic       wdog_err, busy;
  logic [1:0] wdog_cnt;
  logic [2:0] wdog_last;

  int n_tests = 0;
  int n_fail  = 0;

  logic [2:0] exp_gnt_q[$];
  logic [2:0] exp_wd_q[$];
  logic [2:0] prev_gnt = '0;

  always #5 clk = ~clk;

  wbc_bus_arbiter #(
    .NUM_MASTERS (3),
    .TIMEOUT     (8),
    .CNT_W       (2)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cyc_i       (cyc),
    .stb_i       (stb),
    .ack_i       (ack),
    .err_i       (err),
    .rty_i       (rty),
    .gnt_o       (gnt),
    .wdog_err_o  (wdog_err),
    .busy_o      (busy),
    .wdog_cnt_o  (wdog_cnt),
    .wdog_last_o (wdog_last),
    .wdog_clr_i  (clr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input logic [2:0] g, input string tag);
    int n = 0;
    do begin
      tick;
      n++;
    end while (gnt == 3'b000 && n < 10);
    chk(tag, gnt, g);
  endtask

  task automatic do_timeout(input logic [2:0] g, input int exp_cnt, input logic [2:0] exp_last);
    int n = 0;
    cyc = g;
    exp_gnt_q.push_back(g);
    wait_gnt(g, "to_gnt");
    stb = 1'b1;
    exp_wd_q.push_back(exp_last);
    while (!wdog_err && n < 20) begin
      tick;
      n++;
    end
    chk("to_fire", wdog_err, 1);
    chk("to_cnt", wdog_cnt, exp_cnt);
    stb = 1'b0;
    cyc = 3'b000;
    tick;
    tick;
  endtask

  // Scoreboard: every new non-zero grant and every watchdog pulse consumes one expectation.
  always @(negedge clk) begin
    if (gnt !== prev_gnt) begin
      if (gnt != 3'b000) begin
        if (exp_gnt_q.size() == 0) chk("sb_gnt_unexp", gnt, 0);
        else chk("sb_gnt", gnt, exp_gnt_q.pop_front());
      end
      prev_gnt = gnt;
    end
    if (wdog_err === 1'b1) begin
      if (exp_wd_q.size() == 0) chk("sb_wd_unexp", 1, 0);
      else chk("sb_wd_last", wdog_last, exp_wd_q.pop_front());
    end
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: bench did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    logic [2:0] rr_exp[4];
    logic [2:0] g;
    rr_exp = '{G_BMC, G_SPIC, G_PCIEC, G_BMC};
    rst = 1'b1; cyc = '0; stb = 1'b0; ack = 1'b0; err = 1'b0; rty = 1'b0; clr = 1'b0;
    repeat (2) tick;
    rst = 1'b0;
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", wdog_err, 0);
    chk("rst_cnt", wdog_cnt, 0);
    chk("rst_last", wdog_last, 0);

    // Single request
    cyc = G_BMC;
    exp_gnt_q.push_back(G_BMC);
    tick;
    chk("single_gnt", gnt, G_BMC);
    chk("single_busy", busy, 1);
    repeat (4) begin
      tick;
      chk("single_hold", gnt, G_BMC);
    end
    cyc = 3'b000;
    tick;
    chk("single_rel", gnt, 0);
    chk("single_idle_busy", busy, 0);

    // Round-robin from a fresh reset
    rst = 1'b1;
    tick;
    rst = 1'b0;
    cyc = 3'b111;
    foreach (rr_exp[k]) exp_gnt_q.push_back(rr_exp[k]);
    wait_gnt(rr_exp[0], "rr_first");
    for (int k = 0; k < 4; k++) begin
      g = gnt;
      repeat (2) tick;
      chk("rr_hold", gnt, rr_exp[k]);
      cyc = (k == 3) ? 3'b000 : (cyc & ~g);
      tick;
      chk("rr_dead", gnt, 0);
      if (k < 3) begin
        cyc = cyc | g;
        tick;
        chk("rr_next", gnt, rr_exp[k+1]);
      end
    end

    // No preemption of master 2 by master 0
    cyc = G_PCIEC;
    exp_gnt_q.push_back(G_PCIEC);
    tick;
    chk("np_gnt", gnt, G_PCIEC);
    cyc = G_PCIEC | G_BMC;
    repeat (4) begin
      tick;
      chk("np_hold", gnt, G_PCIEC);
    end
    cyc = G_BMC;
    tick;
    chk("np_dead", gnt, 0);
    exp_gnt_q.push_back(G_BMC);
    tick;
    chk("np_next", gnt, G_BMC);
    cyc = 3'b000;
    tick;

    // Watchdog fires once; a late ack in FLUSH is ignored
    cyc = G_SPIC;
    exp_gnt_q.push_back(G_SPIC);
    tick;
    chk("wd_gnt", gnt, G_SPIC);
    stb = 1'b1;
    exp_wd_q.push_back(G_SPIC);
    for (int i = 0; i < 7; i++) begin
      tick;
      chk("wd_quiet", wdog_err, 0);
    end
    tick;
    chk("wd_fire", wdog_err, 1);
    chk("wd_cnt", wdog_cnt, 1);
    chk("wd_last", wdog_last, G_SPIC);
    tick;
    chk("wd_one_clk", wdog_err, 0);
    chk("wd_flush_hold", gnt, G_SPIC);
    ack = 1'b1;
    tick;
    ack = 1'b0;
    chk("wd_late_ack", wdog_err, 0);
    repeat (3) tick;
    chk("wd_cnt_frozen", wdog_cnt, 1);
    stb = 1'b0;
    cyc = 3'b000;
    tick;
    chk("wd_rel", gnt, 0);

    // Ack on the firing cycle wins; counter restarts from zero
    cyc = G_PCIEC;
    exp_gnt_q.push_back(G_PCIEC);
    tick;
    chk("race_gnt", gnt, G_PCIEC);
    stb = 1'b1;
    repeat (7) tick;
    ack = 1'b1;
    tick;
    ack = 1'b0;
    chk("race_noerr", wdog_err, 0);
    chk("race_cnt", wdog_cnt, 1);
    exp_wd_q.push_back(G_PCIEC);
    for (int i = 0; i < 7; i++) begin
      tick;
      chk("race_restart", wdog_err, 0);
    end
    tick;
    chk("race_fire", wdog_err, 1);
    chk("race_cnt2", wdog_cnt, 2);
    stb = 1'b0;
    cyc = 3'b000;
    tick;
    chk("race_rel", gnt, 0);

    // Owner drops cyc on the firing cycle
    cyc = G_BMC;
    exp_gnt_q.push_back(G_BMC);
    tick;
    chk("drop_gnt", gnt, G_BMC);
    stb = 1'b1;
    repeat (7) tick;
    cyc = 3'b000;
    tick;
    chk("drop_noerr", wdog_err, 0);
    chk("drop_rel", gnt, 0);
    chk("drop_cnt", wdog_cnt, 2);
    stb = 1'b0;

    // Asynchronous reset mid-strobe
    cyc = G_SPIC;
    exp_gnt_q.push_back(G_SPIC);
    tick;
    chk("ar_gnt", gnt, G_SPIC);
    stb = 1'b1;
    repeat (3) tick;
    rst = 1'b1;
    #1;
    chk("ar_gnt_async", gnt, 0);
    chk("ar_busy", busy, 0);
    chk("ar_cnt", wdog_cnt, 0);
    cyc = 3'b000;
    stb = 1'b0;
    tick;
    rst = 1'b0;
    chk("ar_err", wdog_err, 0);

    // Saturation and clear
    for (int i = 0; i < 5; i++) do_timeout(G_BMC, (i + 1 > 3) ? 3 : i + 1, G_BMC);
    chk("sat_cnt", wdog_cnt, 3);
    clr = 1'b1;
    tick;
    clr = 1'b0;
    chk("clr_cnt", wdog_cnt, 0);
    chk("clr_last", wdog_last, 0);

    // Clear coincident with a watchdog event
    do_timeout(G_BMC, 1, G_BMC);
    cyc = G_BMC;
    exp_gnt_q.push_back(G_BMC);
    wait_gnt(G_BMC, "cr_gnt");
    stb = 1'b1;
    exp_wd_q.push_back(3'b000);
    repeat (7) tick;
    clr = 1'b1;
    tick;
    clr = 1'b0;
    chk("cr_err", wdog_err, 1);
    chk("cr_cnt", wdog_cnt, 0);
    chk("cr_last", wdog_last, 0);
    stb = 1'b0;
    cyc = 3'b000;
    repeat (2) tick;

    chk("sb_gnt_drain", exp_gnt_q.size(), 0);
    chk("sb_wd_drain", exp_wd_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wbc_bus_arbiter.md
# wbc_bus_arbiter

Round-robin bus arbiter with a transaction watchdog for the shared WISHBONE control interconnect. It grants one master at a time from the BMC, SPI and PCIe controllers. Each grant is held for the master's whole cycle. A bus error is raised to the granted master if the selected slave never terminates a strobe within a fixed number of clocks. It sits between the masters' `cyc` lines and the interconnect's grant-based muxing, and replaces the plain arbiter there.

## Interface
- `NUM_MASTERS`, 3: number of requesting masters. Index 0 = bmc, 1 = spic, 2 = pciec.
- `TIMEOUT`, 1024: clocks a granted strobe may remain unterminated before the watchdog fires. Must be ≥2.
- `CNT_W`, 16: width of the timeout event counter.

Ports (name, direction, width, meaning):
- `clk_i` in 1: interconnect clock.
- `rst_i` in 1: reset; asynchronous, active-high.
- `cyc_i` in NUM_MASTERS: per-master cycle request.
- `stb_i` in 1: strobe of the currently granted master, already muxed.
- `ack_i`, `err_i`, `rty_i` in 1 each: muxed slave termination.
- `gnt_o` out NUM_MASTERS: one-hot grant, registered.
- `wdog_err_o` out 1: watchdog error pulse. The interconnect ORs it into the granted master's err.
- `busy_o` out 1: a grant is active.
- `wdog_cnt_o` out CNT_W: saturating count of watchdog events.
- `wdog_last_o` out NUM_MASTERS: one-hot owner at the most recent watchdog event.
- `wdog_clr_i` in 1: synchronous clear of `wdog_cnt_o` and `wdog_last_o`.

## Operation
- FSM states: IDLE, OWN, FLUSH.
- IDLE:
  - If any `cyc_i` bit is set, grant the first requester found searching upward from (last owner + 1) mod NUM_MASTERS, wrapping.
  - Load that master into `gnt_o`, update the last-owner pointer, go to OWN.
  - The pointer resets to NUM_MASTERS-1, so master 0 has first priority after reset.
- OWN:
  - Grant held unchanged.
  - If the owner's `cyc_i` is low, clear `gnt_o` and go to IDLE.
  - Requests from other masters never preempt the owner.
- Watchdog counter (`$clog2(TIMEOUT+1)` bits), active only in OWN:
  - Clears when `stb_i` is low or when any of `ack_i|err_i|rty_i` is high.
  - Otherwise increments.
  - When it reaches TIMEOUT-1 with no termination that cycle: assert `wdog_err_o` next cycle for exactly one clock, increment `wdog_cnt_o` (saturating at all-ones), load `wdog_last_o` = `gnt_o`, go to FLUSH.
- FLUSH:
  - Grant held, `wdog_err_o` low.
  - Wait for the owner's `cyc_i` to drop, then clear `gnt_o` and go to IDLE.
  - Late slave terminations are ignored: no second error, counter frozen.
- Simultaneous events:
  - Termination on the firing cycle wins; no watchdog error.
  - Owner drops `cyc_i` on the firing cycle: no error, go to IDLE.
  - `wdog_clr_i` coincident with an event: clear wins, count reads 0.
- Reset:
  - All outputs 0, FSM IDLE, counters 0.
  - Reset mid-cycle drops the grant immediately (asynchronous) and issues no error.

## Timing
- Grant latency: `cyc_i` rises at edge N, `gnt_o` is valid after edge N+1.
- Release: owner `cyc_i` falls, `gnt_o` clears after the next edge.
- One dead cycle in IDLE always separates consecutive grants, including same-master re-requests.
- Watchdog: `stb_i` rises with grant held and no termination; `wdog_err_o` is high during the (TIMEOUT+1)-th clock after strobe assertion.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- A shared package (`wbc_pkg`) holds:
  - master index constants (`WBC_M_BMC=0`, `WBC_M_SPIC=1`, `WBC_M_PCIEC=2`);
  - FSM state encoding;
  - default `TIMEOUT`.
- One natural sub-module: `rr_pick`, combinational. Inputs are the request vector and last-owner pointer; output is the one-hot next grant. It is reusable for other round-robin resources.
- The watchdog and FSM live in the top module.

## Test plan
- Single request: `cyc_i`=3'b001 held 5 clocks. `gnt_o`=001 from the 2nd edge, clears 1 clock after `cyc` drops, `busy_o` tracks it.
- Round-robin: all three `cyc_i` held permanently, each dropping `cyc` 3 clocks after its grant. Grant order 001→010→100→001, one idle clock between grants.
- No preemption: master 2 owns the bus while master 0 requests. `gnt_o` stays 100 until master 2 drops `cyc`.
- Watchdog: TIMEOUT=8, strobe held with no ack. `wdog_err_o` pulses once on the 9th clock; `wdog_cnt_o`=1; `wdog_last_o`=owner. An `ack_i` arriving later in FLUSH produces no second pulse.
- Race: TIMEOUT=8, `ack_i` on exactly the firing cycle. No error, count unchanged, the next strobe restarts the counter from 0.
- Reset/clear: `rst_i` asserted mid-strobe clears `gnt_o` asynchronously. With CNT_W=2 and 5 timeouts, `wdog_cnt_o` saturates at 3. `wdog_clr_i` then returns it to 0.
